// File: rtl/maze_neighbor_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | maze_neighbor_gen_if : raster-in / wall-neighbourhood-out bundle            |
// | Diagonal outputs exist only with MAZE_NEIGHBOR_DIAG_EN.  Rev 1.0            |
// +----------------------------------------------------------------------------+
interface maze_neighbor_gen_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       maze_bit;
  logic       currentMazePrime;
  logic       MazeUpPrime;
  logic       MazeDownPrime;
  logic       MazeLeftPrime;
  logic       MazeRightPrime;
  logic [9:0] MazeX;
  logic [9:0] MazeY;
  logic       maze_valid;
`ifdef MAZE_NEIGHBOR_DIAG_EN
  logic       MazeUpLeftPrime;
  logic       MazeUpRightPrime;
  logic       MazeDownLeftPrime;
  logic       MazeDownRightPrime;
`endif

  modport master (
`ifdef MAZE_NEIGHBOR_DIAG_EN
    input  MazeUpLeftPrime, MazeUpRightPrime, MazeDownLeftPrime, MazeDownRightPrime,
`endif
    output DrawX, DrawY, maze_bit,
    input  currentMazePrime, MazeUpPrime, MazeDownPrime, MazeLeftPrime,
    input  MazeRightPrime, MazeX, MazeY, maze_valid
  );

  modport slave (
`ifdef MAZE_NEIGHBOR_DIAG_EN
    output MazeUpLeftPrime, MazeUpRightPrime, MazeDownLeftPrime, MazeDownRightPrime,
`endif
    input  DrawX, DrawY, maze_bit,
    output currentMazePrime, MazeUpPrime, MazeDownPrime, MazeLeftPrime,
    output MazeRightPrime, MazeX, MazeY, maze_valid
  );
endinterface
`default_nettype wire

// File: rtl/maze_neighbor_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | maze_neighbor_gen : per-pixel wall bit plus 4 (or 8) neighbours from raster |
// | Optional diagonals: MAZE_NEIGHBOR_DIAG_EN.  Rev 1.0                          |
// +----------------------------------------------------------------------------+
module maze_neighbor_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter bit EDGE_VAL = 1'b1
) (
  input wire logic           pixel_clk,
  input wire logic           Reset,
  maze_neighbor_gen_if.slave bus
);
  localparam int         c_AW = $clog2(H_ACTIVE + 1);
  localparam logic [9:0] c_H  = 10'(H_ACTIVE);
  localparam logic [9:0] c_V  = 10'(V_ACTIVE);

  logic r_lb1 [0:H_ACTIVE];
  logic r_lb2 [0:H_ACTIVE];

  logic            w_accept;
  logic            w_active;
  logic            w_emit;
  logic            w_s;
  logic            w_c0_top;
  logic            w_c0_mid;
  logic            w_top_row;
  logic            w_left_col;
  logic [c_AW-1:0] w_idx;

  logic       r_c1_top, r_c1_mid, r_c1_bot;
  logic       r_c2_mid;
  logic       r_cur, r_up, r_down, r_left, r_right;
  logic [9:0] r_maze_x, r_maze_y;
  logic       r_valid;
  logic       r_armed;
`ifdef MAZE_NEIGHBOR_DIAG_EN
  logic       r_c2_top, r_c2_bot;
  logic       r_ul, r_ur, r_dl, r_dr;
`endif

  // The flush column/line sit one past the active area and inject EDGE_VAL.
  assign w_accept   = (bus.DrawX <= c_H) && (bus.DrawY <= c_V);
  assign w_active   = (bus.DrawX <  c_H) && (bus.DrawY <  c_V);
  assign w_s        = w_active ? bus.maze_bit : EDGE_VAL;
  assign w_idx      = bus.DrawX[c_AW-1:0];
  assign w_c0_top   = r_lb2[w_idx];
  assign w_c0_mid   = r_lb1[w_idx];
  assign w_emit     = w_accept && (bus.DrawX != 10'd0) && (bus.DrawY != 10'd0);
  assign w_top_row  = (bus.DrawY == 10'd1);
  assign w_left_col = (bus.DrawX == 10'd1);

  always_ff @(posedge pixel_clk) begin
    if (w_accept) begin
      r_lb2[w_idx] <= w_c0_mid;
      r_lb1[w_idx] <= w_s;
    end
  end

  always_ff @(posedge pixel_clk or posedge Reset) begin
    if (Reset) begin
      r_c1_top <= EDGE_VAL;
      r_c1_mid <= EDGE_VAL;
      r_c1_bot <= EDGE_VAL;
      r_c2_mid <= EDGE_VAL;
      r_cur    <= 1'b0;
      r_up     <= 1'b0;
      r_down   <= 1'b0;
      r_left   <= 1'b0;
      r_right  <= 1'b0;
      r_maze_x <= 10'd0;
      r_maze_y <= 10'd0;
      r_valid  <= 1'b0;
      r_armed  <= 1'b0;
`ifdef MAZE_NEIGHBOR_DIAG_EN
      r_c2_top <= EDGE_VAL;
      r_c2_bot <= EDGE_VAL;
      r_ul     <= 1'b0;
      r_ur     <= 1'b0;
      r_dl     <= 1'b0;
      r_dr     <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      if ((bus.DrawX == 10'd0) && (bus.DrawY == 10'd0)) begin
        r_armed <= 1'b1;
      end
      if (w_accept) begin
        // Outputs read c1/c2 before this shift, i.e. columns X-1 and X-2.
        if (w_emit) begin
          r_maze_x <= bus.DrawX - 10'd1;
          r_maze_y <= bus.DrawY - 10'd1;
          r_cur    <= r_c1_mid;
          r_down   <= r_c1_bot;
          r_up     <= w_top_row  ? EDGE_VAL : r_c1_top;
          r_left   <= w_left_col ? EDGE_VAL : r_c2_mid;
          r_right  <= w_c0_mid;
          r_valid  <= r_armed;
`ifdef MAZE_NEIGHBOR_DIAG_EN
          r_ul     <= (w_top_row || w_left_col) ? EDGE_VAL : r_c2_top;
          r_ur     <= w_top_row  ? EDGE_VAL : w_c0_top;
          r_dl     <= w_left_col ? EDGE_VAL : r_c2_bot;
          r_dr     <= w_s;
`endif
        end
        if (bus.DrawX == 10'd0) begin
          r_c2_mid <= EDGE_VAL;
`ifdef MAZE_NEIGHBOR_DIAG_EN
          r_c2_top <= EDGE_VAL;
          r_c2_bot <= EDGE_VAL;
`endif
        end else begin
          r_c2_mid <= r_c1_mid;
`ifdef MAZE_NEIGHBOR_DIAG_EN
          r_c2_top <= r_c1_top;
          r_c2_bot <= r_c1_bot;
`endif
        end
        r_c1_top <= w_c0_top;
        r_c1_mid <= w_c0_mid;
        r_c1_bot <= w_s;
      end
    end
  end

  assign bus.currentMazePrime = r_cur;
  assign bus.MazeUpPrime      = r_up;
  assign bus.MazeDownPrime    = r_down;
  assign bus.MazeLeftPrime    = r_left;
  assign bus.MazeRightPrime   = r_right;
  assign bus.MazeX            = r_maze_x;
  assign bus.MazeY            = r_maze_y;
  assign bus.maze_valid       = r_valid;
`ifdef MAZE_NEIGHBOR_DIAG_EN
  assign bus.MazeUpLeftPrime    = r_ul;
  assign bus.MazeUpRightPrime   = r_ur;
  assign bus.MazeDownLeftPrime  = r_dl;
  assign bus.MazeDownRightPrime = r_dr;
`endif
endmodule
`default_nettype wire

// File: tb/tb_maze_neighbor_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_maze_neighbor_gen : raster-driven bench with a 2-D maze reference model  |
// | Small frame geometry keeps whole frames short.  Rev 1.0                     |
// +----------------------------------------------------------------------------+
module tb_maze_neighbor_gen;
  localparam int c_H    = 16;
  localparam int c_V    = 10;
  localparam int c_HT   = 20;
  localparam int c_VT   = 13;
  localparam bit c_EDGE = 1'b1;
  // bit positions in the neighbourhood vector
  localparam int c_CUR = 8, c_UP = 7, c_DN = 6, c_LF = 5, c_RT = 4;
  localparam int c_UL = 3, c_UR = 2, c_DL = 1, c_DR = 0;

  logic pixel_clk = 1'b0;
  logic Reset     = 1'b1;
  always #5 pixel_clk = ~pixel_clk;

  maze_neighbor_gen_if u_if ();

  maze_neighbor_gen #(
    .H_ACTIVE(c_H),
    .V_ACTIVE(c_V),
    .EDGE_VAL(c_EDGE)
  ) dut (
    .pixel_clk(pixel_clk),
    .Reset    (Reset),
    .bus      (u_if)
  );

  bit         maze [c_V][c_H];
  logic [8:0] cap  [c_V][c_H];
  int         checks   = 0;
  int         failures = 0;
  int         pulses   = 0;
  bit         armed_m;
  bit         exp_valid;
  bit         known;
  int         exp_x, exp_y;
  logic [8:0] exp_nb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit m(input int x, input int y);
    if (x < 0 || x >= c_H || y < 0 || y >= c_V) return c_EDGE;
    return maze[y][x];
  endfunction

  function automatic logic [8:0] gold(input int x, input int y);
    logic [8:0] g;
    g = {m(x, y), m(x, y-1), m(x, y+1), m(x-1, y), m(x+1, y), 4'b0};
`ifdef MAZE_NEIGHBOR_DIAG_EN
    g[3:0] = {m(x-1, y-1), m(x+1, y-1), m(x-1, y+1), m(x+1, y+1)};
`endif
    return g;
  endfunction

  function automatic logic [8:0] obs_nb();
    logic [8:0] o;
    o = {u_if.currentMazePrime, u_if.MazeUpPrime, u_if.MazeDownPrime,
         u_if.MazeLeftPrime, u_if.MazeRightPrime, 4'b0};
`ifdef MAZE_NEIGHBOR_DIAG_EN
    o[3:0] = {u_if.MazeUpLeftPrime, u_if.MazeUpRightPrime,
              u_if.MazeDownLeftPrime, u_if.MazeDownRightPrime};
`endif
    return o;
  endfunction

  task automatic observe();
    logic [8:0] o;
    o = obs_nb();
    chk("valid", {31'd0, u_if.maze_valid}, {31'd0, exp_valid});
    chk("mazex", {22'd0, u_if.MazeX}, exp_x);
    chk("mazey", {22'd0, u_if.MazeY}, exp_y);
    if (known) chk($sformatf("nbrs(%0d,%0d)", exp_x, exp_y), {23'd0, o}, {23'd0, exp_nb});
    if (exp_valid && u_if.maze_valid === 1'b1) begin
      pulses++;
      cap[exp_y][exp_x] = o;
    end
  endtask

  // Drive one raster sample and predict what the next sample point shows.
  task automatic drive(input int x, input int y, input bit b, input bit r);
    Reset         = r;
    u_if.DrawX    = 10'(x);
    u_if.DrawY    = 10'(y);
    u_if.maze_bit = b;
    if (r) begin
      armed_m = 0; exp_valid = 0; exp_x = 0; exp_y = 0; exp_nb = '0; known = 1;
    end else begin
      exp_valid = 0;
      if (x == 0 && y == 0) armed_m = 1;
      if (x >= 1 && x <= c_H && y >= 1 && y <= c_V) begin
        exp_x     = x - 1;
        exp_y     = y - 1;
        exp_valid = armed_m;
        known     = armed_m;
        if (armed_m) exp_nb = gold(x - 1, y - 1);
      end
    end
  endtask

  task automatic step(input int x, input int y, input bit r);
    bit b;
    b = (x < c_H && y < c_V) ? maze[y][x] : 1'($urandom_range(0, 1));
    @(negedge pixel_clk);
    observe();
    drive(x, y, b, r);
  endtask

  task automatic latency_probe();
    @(negedge pixel_clk);
    observe();
    chk("lat_x", {22'd0, u_if.MazeX}, 10);
    chk("lat_y", {22'd0, u_if.MazeY}, 5);
    chk("lat_valid", {31'd0, u_if.maze_valid}, 1);
    drive(700, 6, 1'b1, 1'b0);
    @(negedge pixel_clk);
    observe();
    chk("hold_valid", {31'd0, u_if.maze_valid}, 0);
    chk("hold_x", {22'd0, u_if.MazeX}, 10);
    chk("hold_y", {22'd0, u_if.MazeY}, 5);
  endtask

  task automatic run_frame(input bit lat_hook, input int rst_on, input int rst_off,
                           input int exp_pulses);
    bit r;
    int p0;
    r  = 0;
    p0 = pulses;
    for (int y = 0; y < c_VT; y++) begin
      for (int x = 0; x < c_HT; x++) begin
        if (x == 0 && y == rst_on)  r = 1;
        if (x == 0 && y == rst_off) r = 0;
        if (lat_hook && x == 12 && y == 6) latency_probe();
        step(x, y, r);
      end
    end
    chk("frame_pulses", pulses - p0, exp_pulses);
  endtask

  task automatic fill(input int mode);
    for (int y = 0; y < c_V; y++) begin
      for (int x = 0; x < c_W(); x++) begin
        case (mode)
          0:       maze[y][x] = 1'b0;
          1:       maze[y][x] = (x == 5 && y == 4);
          2:       maze[y][x] = (x == c_H - 1) || (y == 0);
          default: maze[y][x] = 1'($urandom_range(0, 1));
        endcase
      end
    end
  endtask

  function automatic int c_W();
    return c_H;
  endfunction

  task automatic cbit(input string tag, input int x, input int y, input int b,
                      input bit expv);
    logic [8:0] v;
    v = cap[y][x];
    chk(tag, {31'd0, v[b]}, {31'd0, expv});
  endtask

  initial begin
    u_if.DrawX    = 10'd799;
    u_if.DrawY    = 10'd524;
    u_if.maze_bit = 1'b0;
    armed_m = 0; exp_valid = 0; exp_x = 0; exp_y = 0; exp_nb = '0; known = 1;
    for (int y = 0; y < c_V; y++)
      for (int x = 0; x < c_H; x++) cap[y][x] = '1;

    repeat (3) step(c_HT - 1, c_VT - 1, 1'b1);
    chk("rst_valid", {31'd0, u_if.maze_valid}, 0);
    chk("rst_x", {22'd0, u_if.MazeX}, 0);
    chk("rst_nbrs", {23'd0, obs_nb()}, 0);

    // Blank maze, two frames
    fill(0);
    run_frame(1'b0, -1, -1, c_H * c_V);
    run_frame(1'b0, -1, -1, c_H * c_V);
    cbit("blank00_cur",   0, 0, c_CUR, 0);
    cbit("blank00_up",    0, 0, c_UP,  1);
    cbit("blank00_left",  0, 0, c_LF,  1);
    cbit("blank00_down",  0, 0, c_DN,  0);
    cbit("blank00_right", 0, 0, c_RT,  0);
    cbit("blankBR_right", c_H - 1, c_V - 1, c_RT, 1);
    cbit("blankBR_down",  c_H - 1, c_V - 1, c_DN, 1);
    chk("blank_center", {23'd0, cap[c_V/2][c_H/2]}, 0);

    // Single wall at (5,4)
    fill(1);
    run_frame(1'b0, -1, -1, c_H * c_V);
    cbit("wall_cur",   5, 4, c_CUR, 1);
    cbit("wall_down",  5, 3, c_DN,  1);
    cbit("wall_up",    5, 5, c_UP,  1);
    cbit("wall_right", 4, 4, c_RT,  1);
    cbit("wall_left",  6, 4, c_LF,  1);
    chk("wall_far", {23'd0, cap[8][10]}, 0);
`ifdef MAZE_NEIGHBOR_DIAG_EN
    cbit("wall_ul",  6, 5, c_UL, 1);
    cbit("wall_dr",  4, 3, c_DR, 1);
    cbit("p00_ul",   0, 0, c_UL, 1);
    cbit("p00_dl",   0, 0, c_DL, 1);
    cbit("p00_ur",   0, 0, c_UR, 1);
`endif

    // Right column and top line walls
    fill(2);
    run_frame(1'b0, -1, -1, c_H * c_V);
    cbit("stripe_a_right", c_H - 2, 0, c_RT, 1);
    cbit("stripe_a_up",    c_H - 2, 0, c_UP, 1);
    cbit("stripe_b_up",    c_H - 1, 1, c_UP, 1);
    cbit("stripe_b_right", c_H - 1, 1, c_RT, 1);

    // Random mazes, latency probe, mid-frame reset and recovery
    fill(3);
    run_frame(1'b1, -1, -1, c_H * c_V);
    fill(3);
    run_frame(1'b0, 5, 7, 4 * c_H);
    fill(3);
    run_frame(1'b0, -1, -1, c_H * c_V);
    fill(3);
    run_frame(1'b0, -1, -1, c_H * c_V);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/maze_neighbor_gen.md
Name: maze_neighbor_gen

Overview:
- Producer side of the per-pixel maze-wall interface consumed by the wall-collision logic.
- Takes the raw 1-bit maze wall sample for the current raster position (DrawX, DrawY).
- Uses two line buffers and a 3-column window to emit, for each active pixel, its own wall bit plus its up, down, left and right neighbour bits, tagged with the pixel's coordinates.
- Sits between the maze ROM lookup and the tank/bullet collision blocks, on the pixel clock.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- EDGE_VAL, 1, value substituted for any neighbour outside the active frame (screen border counts as wall).

Ports:
- pixel_clk  in  1  pixel clock; all state on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- DrawX  in  10  current raster column, 0..799.
- DrawY  in  10  current raster line, 0..524.
- maze_bit  in  1  wall bit for (DrawX, DrawY); meaningful only when DrawX<H_ACTIVE and DrawY<V_ACTIVE.
- currentMazePrime  out  1  wall bit of pixel (MazeX, MazeY).
- MazeUpPrime  out  1  wall bit of (MazeX, MazeY-1).
- MazeDownPrime  out  1  wall bit of (MazeX, MazeY+1).
- MazeLeftPrime  out  1  wall bit of (MazeX-1, MazeY).
- MazeRightPrime  out  1  wall bit of (MazeX+1, MazeY).
- MazeX  out  10  column of the pixel described by the outputs.
- MazeY  out  10  line of the pixel described by the outputs.
- maze_valid  out  1  outputs describe a real active pixel this cycle.

Behaviour:
- Accepted sample: a cycle with DrawX<=H_ACTIVE and DrawY<=V_ACTIVE.
  - s = maze_bit if DrawX<H_ACTIVE and DrawY<V_ACTIVE, else EDGE_VAL.
  - Flush column (DrawX==H_ACTIVE) and flush line (DrawY==V_ACTIVE) exist to complete the right and bottom neighbours.
  - All other cycles are ignored: window, buffers and outputs hold, except maze_valid, which is 0.
- Line buffers: lb1 holds line Y-1, lb2 holds line Y-2; each has H_ACTIVE+1 one-bit entries indexed by DrawX.
  - On an accepted sample at X: read lb1[X] and lb2[X], then write lb2[X]=old lb1[X] and lb1[X]=s.
- Window:
  - New column c0 = {top=lb2[X], mid=lb1[X], bot=s}.
  - Registered columns c1 (column X-1) and c2 (column X-2) shift c0→c1→c2 on each accepted sample.
  - When an accepted sample has DrawX==0, c1 and c2 are loaded with all-EDGE_VAL before the shift.
- Output registers, updated on every accepted sample with X>=1 and Y>=1:
  - MazeX=X-1, MazeY=Y-1.
  - currentMazePrime=c1.mid, MazeDownPrime=c1.bot.
  - MazeUpPrime = EDGE_VAL if Y==1, else c1.top.
  - MazeLeftPrime = EDGE_VAL if X==1, else c2.mid.
  - MazeRightPrime=c0.mid.
  - maze_valid=1 if the frame is armed, else 0.
- Latency: data for pixel (x,y) appears the cycle after DrawX=x+1, DrawY=y+1 is presented. Exactly one maze_valid pulse per active pixel per frame, in raster order.
- Arming:
  - armed is cleared by Reset.
  - armed is set on the first cycle with DrawX==0 and DrawY==0 and stays set until the next Reset.
  - While not armed, maze_valid=0 even when other outputs update. This guarantees no partial frame is reported after a mid-frame reset.
- Reset: all outputs, MazeX and MazeY go to 0; maze_valid=0, armed=0; c1 and c2 go to EDGE_VAL. Line-buffer contents are not reset; stale data is masked by arming and the Y==1 rule.
- No arithmetic wrap: X-1 and Y-1 are computed only when X>=1 and Y>=1.

Optional Feature:
- Macro: MAZE_NEIGHBOR_DIAG_EN.
- When defined, four extra 1-bit outputs are added: MazeUpLeftPrime, MazeUpRightPrime, MazeDownLeftPrime, MazeDownRightPrime.
  - MazeUpLeftPrime = c2.top, MazeUpRightPrime = c0.top, MazeDownLeftPrime = c2.bot, MazeDownRightPrime = c0.bot.
  - Same edge substitution rules apply: up edge when Y==1, left edge when X==1.
  - Same latency as the other outputs.
- When not defined, these ports and c2.top/c2.bot storage do not exist; behaviour is otherwise identical.

Test Plan:
- Blank maze (maze_bit=0 always), two full frames → 307200 maze_valid pulses per frame.
  - Pixel (0,0): current=0, Up=1, Left=1, Down=0, Right=0.
  - Pixel (639,479): Right=1, Down=1.
  - Pixel (320,240): all outputs 0.
- Single wall pixel at (100,50), else 0 → exactly these pulses show a 1:
  - (100,50) current=1; (100,49) Down=1; (100,51) Up=1; (99,50) Right=1; (101,50) Left=1.
- Latency check: present DrawX=11, DrawY=6 → next cycle MazeX=10, MazeY=5, maze_valid=1. During DrawX=700 → maze_valid=0 and the other outputs hold.
- Reset asserted at DrawY=200, released at DrawY=210 → maze_valid stays 0 until after DrawX=0, DrawY=0. The following frame matches the golden model bit-exactly.
- Vertical stripe at column 639 and horizontal stripe at line 0 → pixel (638,0) Right=1, Up=1; pixel (639,1) Up=1, Right=1 (edge).
- With MAZE_NEIGHBOR_DIAG_EN, single wall at (100,50):
  - Pixel (101,51) UpLeft=1.
  - Pixel (99,49) DownRight=1.
  - Pixel (0,0) UpLeft=1, DownLeft=1, UpRight=1.
